// File: rtl/ra_bist_march.sv
// March C- memory BIST controller with functional-path muxing, pipelined read
// compare and first-fail capture. Status/control words are MSB-first [0:31].
module ra_bist_march #(
  parameter int unsigned AW    = 6,
  parameter int unsigned DW    = 72,
  parameter int unsigned NR    = 2,
  parameter int unsigned RDLAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:31]       ctl,
  output logic [0:31]       status,
  input  logic [NR-1:0]     rd_enb_in,
  input  logic [NR*AW-1:0]  rd_adr_in,
  input  logic [NR*DW-1:0]  rd_dat,
  input  logic              wr_enb_in,
  input  logic [AW-1:0]     wr_adr_in,
  input  logic [DW-1:0]     wr_dat_in,
  output logic [NR-1:0]     rd_enb_out,
  output logic [NR*AW-1:0]  rd_adr_out,
  output logic              wr_enb_out,
  output logic [AW-1:0]     wr_adr_out,
  output logic [DW-1:0]     wr_dat_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AW-1:0] ADR_LAST   = '1;
  localparam logic [15:0]   DRAIN_LAST = 16'(RDLAT - 1);

  logic [1:0]    state_q, state_d;
  logic [2:0]    elem_q, elem_d;
  logic [AW-1:0] adr_q, adr_d;
  logic          op_q, op_d;
  logic [15:0]   drain_q, drain_d;
  logic          start_prev_q;
  logic          bg_q;
  logic [3:0]    mask_q;

  logic          fail_q;
  logic [7:0]    cnt_q;
  logic [2:0]    ffelem_q;
  logic [1:0]    ffport_q;
  logic [AW-1:0] ffadr_q;

  logic          pv_q    [RDLAT];
  logic [DW-1:0] pdat_q  [RDLAT];
  logic [2:0]    pelem_q [RDLAT];
  logic [AW-1:0] padr_q  [RDLAT];

  logic          busy, start_go, abort;
  logic          up, is_rd, last_op, last_adr, data_one;
  logic [DW-1:0] pat;
  logic [NR-1:0] mis;
  logic          mis_any;
  logic [1:0]    mis_port;
  logic          unused_ctl;

  assign unused_ctl = ^{ctl[3], ctl[8:31]};

  assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign abort    = busy && ctl[1];
  assign start_go = ctl[0] && !start_prev_q && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Decode the current March C- operation from element and op slot
  always_comb begin
    up       = (elem_q < 3'd3);
    is_rd    = (elem_q != 3'd0) && !op_q;
    last_op  = ((elem_q == 3'd0) || (elem_q == 3'd5)) ? 1'b1 : op_q;
    last_adr = up ? (adr_q == ADR_LAST) : (adr_q == '0);
    if (is_rd) data_one = (elem_q == 3'd2) || (elem_q == 3'd4);
    else       data_one = (elem_q == 3'd1) || (elem_q == 3'd3);
  end

  // Background pattern for the current address, inverted for "1" data
  always_comb begin
    pat = '0;
    if (bg_q) begin
      for (int unsigned j = 0; j < DW; j++) begin
        pat[DW-1-j] = ((j % 2) == 1) ^ adr_q[AW-1];
      end
    end
    pat = pat ^ {DW{data_one}};
  end

  // Sequencer next state: addresses advance only after the last op of an element step
  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    adr_d   = adr_q;
    op_d    = op_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_go) begin
          state_d = S_RUN;
          elem_d  = '0;
          adr_d   = '0;
          op_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!last_op) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (!last_adr) begin
            adr_d = up ? adr_q + 1'b1 : adr_q - 1'b1;
          end else if (elem_q == 3'd5) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            elem_d = elem_q + 3'd1;
            adr_d  = (elem_q >= 3'd2) ? '1 : '0;
          end
        end
      end
      default: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 16'd1;
        end
      end
    endcase
  end

  // Sequencer and latched-configuration registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      elem_q       <= '0;
      adr_q        <= '0;
      op_q         <= 1'b0;
      drain_q      <= '0;
      start_prev_q <= 1'b0;
      bg_q         <= 1'b0;
      mask_q       <= '0;
    end else begin
      state_q      <= state_d;
      elem_q       <= elem_d;
      adr_q        <= adr_d;
      op_q         <= op_d;
      drain_q      <= drain_d;
      start_prev_q <= ctl[0];
      if (start_go) begin
        bg_q   <= ctl[2];
        mask_q <= {ctl[7], ctl[6], ctl[5], ctl[4]};
      end
    end
  end

  // Expected-data pipeline aligned with the array read latency
  always_ff @(posedge clk) begin
    pdat_q[0]  <= pat;
    pelem_q[0] <= elem_q;
    padr_q[0]  <= adr_q;
    for (int unsigned k = 1; k < RDLAT; k++) begin
      pdat_q[k]  <= pdat_q[k-1];
      pelem_q[k] <= pelem_q[k-1];
      padr_q[k]  <= padr_q[k-1];
    end
    if (reset || abort || start_go) begin
      for (int unsigned k = 0; k < RDLAT; k++) pv_q[k] <= 1'b0;
    end else begin
      pv_q[0] <= (state_q == S_RUN) && is_rd;
      for (int unsigned k = 1; k < RDLAT; k++) pv_q[k] <= pv_q[k-1];
    end
  end

  // Per-port compare of returned data; lowest mismatching port wins
  always_comb begin
    logic found;
    mis      = '0;
    mis_port = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (pv_q[RDLAT-1] && mask_q[i] && (rd_dat[i*DW +: DW] != pdat_q[RDLAT-1])) begin
        mis[i] = 1'b1;
        if (!found) begin
          mis_port = 2'(i);
          found    = 1'b1;
        end
      end
    end
    mis_any = |mis;
  end

  // Fail flag, saturating count and first-fail capture
  always_ff @(posedge clk) begin
    if (reset || start_go) begin
      fail_q   <= 1'b0;
      cnt_q    <= '0;
      ffelem_q <= '0;
      ffport_q <= '0;
      ffadr_q  <= '0;
    end else if (busy && !abort && mis_any) begin
      fail_q <= 1'b1;
      if (cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
      if (!fail_q) begin
        ffelem_q <= pelem_q[RDLAT-1];
        ffadr_q  <= padr_q[RDLAT-1];
        ffport_q <= mis_port;
      end
    end
  end

  // Status word assembly
  always_comb begin
    status        = '0;
    status[0]     = busy;
    status[1]     = (state_q == S_DONE);
    status[2]     = fail_q;
    status[3:5]   = ffelem_q;
    status[6:7]   = ffport_q;
    status[8:15]  = cnt_q;
    status[16:31] = 16'(ffadr_q);
  end

  // Array request mux: BIST owns the array while busy, functional path otherwise
  always_comb begin
    if (busy) begin
      rd_enb_out = ((state_q == S_RUN) && is_rd) ? '1 : '0;
      rd_adr_out = {NR{adr_q}};
      wr_enb_out = (state_q == S_RUN) && !is_rd;
      wr_adr_out = adr_q;
      wr_dat_out = pat;
    end else begin
      rd_enb_out = rd_enb_in;
      rd_adr_out = rd_adr_in;
      wr_enb_out = wr_enb_in;
      wr_adr_out = wr_adr_in;
      wr_dat_out = wr_dat_in;
    end
  end

endmodule

// File: tb/tb_ra_bist_march.sv
// Self-checking bench for ra_bist_march: array model with fault injection,
// March C- reference built from the algorithm description.
module tb_ra_bist_march;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 72;
  localparam int unsigned NR = 2;
  localparam int unsigned N  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [0:31]      ctl, status;
  logic [NR-1:0]    rd_enb_in, rd_enb_out;
  logic [NR*AW-1:0] rd_adr_in, rd_adr_out;
  logic [NR*DW-1:0] rd_dat;
  logic             wr_enb_in, wr_enb_out;
  logic [AW-1:0]    wr_adr_in, wr_adr_out;
  logic [DW-1:0]    wr_dat_in, wr_dat_out;

  logic [0:31] ctl2, status2;
  logic [1:0]  rd_enb_in2, rd_enb_out2;
  logic [7:0]  rd_adr_in2, rd_adr_out2;
  logic [31:0] rd_dat2, rd_s1;
  logic        wr_enb_in2, wr_enb_out2;
  logic [3:0]  wr_adr_in2, wr_adr_out2;
  logic [15:0] wr_dat_in2, wr_dat_out2;

  ra_bist_march #(.AW(AW), .DW(DW), .NR(NR), .RDLAT(1)) dut (
    .clk(clk), .reset(reset), .ctl(ctl), .status(status),
    .rd_enb_in(rd_enb_in), .rd_adr_in(rd_adr_in), .rd_dat(rd_dat),
    .wr_enb_in(wr_enb_in), .wr_adr_in(wr_adr_in), .wr_dat_in(wr_dat_in),
    .rd_enb_out(rd_enb_out), .rd_adr_out(rd_adr_out),
    .wr_enb_out(wr_enb_out), .wr_adr_out(wr_adr_out), .wr_dat_out(wr_dat_out));

  ra_bist_march #(.AW(4), .DW(16), .NR(2), .RDLAT(2)) dut2 (
    .clk(clk), .reset(reset), .ctl(ctl2), .status(status2),
    .rd_enb_in(rd_enb_in2), .rd_adr_in(rd_adr_in2), .rd_dat(rd_dat2),
    .wr_enb_in(wr_enb_in2), .wr_adr_in(wr_adr_in2), .wr_dat_in(wr_dat_in2),
    .rd_enb_out(rd_enb_out2), .rd_adr_out(rd_adr_out2),
    .wr_enb_out(wr_enb_out2), .wr_adr_out(wr_adr_out2), .wr_dat_out(wr_dat_out2));

  // Fault configuration: ports in f_pm, one address or all, one bit; mode 0/1 stuck, 2 invert
  logic       f_en;
  logic [1:0] f_pm;
  bit         f_all;
  int         f_adr, f_bit, f_mode;

  function automatic logic [DW-1:0] faulty(logic [DW-1:0] d, int p, int a);
    logic [DW-1:0] r;
    r = d;
    if (f_en && f_pm[p] && (f_all || a == f_adr)) begin
      if (f_mode == 0)      r[f_bit] = 1'b0;
      else if (f_mode == 1) r[f_bit] = 1'b1;
      else                  r[f_bit] = ~r[f_bit];
    end
    return r;
  endfunction

  logic [DW-1:0] mem1 [N];
  always @(posedge clk) begin
    if (wr_enb_out) mem1[wr_adr_out] <= wr_dat_out;
    for (int p = 0; p < NR; p++)
      if (rd_enb_out[p])
        rd_dat[p*DW +: DW] <= faulty(mem1[rd_adr_out[p*AW +: AW]], p, int'(rd_adr_out[p*AW +: AW]));
  end

  logic [15:0] mem2 [16];
  always @(posedge clk) begin
    if (wr_enb_out2) mem2[wr_adr_out2] <= wr_dat_out2;
    for (int p = 0; p < 2; p++) rd_s1[p*16 +: 16] <= mem2[rd_adr_out2[p*4 +: 4]];
    rd_dat2 <= rd_s1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // March C- as written: op codes 0=r0 1=r1 2=w0 3=w1, -1 unused slot
  int march_ops [6][2] = '{'{2, -1}, '{0, 3}, '{1, 2}, '{0, 3}, '{1, 2}, '{0, -1}};

  typedef struct {
    bit            rd;
    logic [AW-1:0] adr;
    int            elem;
    logic [DW-1:0] dat;
  } op_t;
  op_t exp_q[$];

  function automatic logic [DW-1:0] bgpat(bit cb, int adr, bit one);
    logic [DW-1:0] b;
    b = '0;
    if (cb) b = {36{2'b01}};
    if (cb && adr >= N/2) b = ~b;
    return one ? ~b : b;
  endfunction

  task automatic build_ops(input bit cb);
    op_t o;
    exp_q.delete();
    for (int e = 0; e < 6; e++)
      for (int k = 0; k < N; k++)
        for (int s = 0; s < 2; s++) begin
          int code;
          int a;
          code = march_ops[e][s];
          a = (e < 3) ? k : N - 1 - k;
          if (code >= 0) begin
            o.rd = (code < 2);
            o.adr = AW'(a);
            o.elem = e;
            o.dat = bgpat(cb, a, (code == 1) || (code == 3));
            exp_q.push_back(o);
          end
        end
  endtask

  task automatic model_result(input logic [3:0] mask, output int fl, output int cnt,
                              output int el, output int pt, output int ad);
    fl = 0; cnt = 0; el = 0; pt = 0; ad = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].rd) begin
        int fp;
        fp = -1;
        for (int p = 0; p < NR; p++)
          if (fp < 0 && f_en && mask[p] && f_pm[p] && (f_all || int'(exp_q[i].adr) == f_adr) &&
              (f_mode == 2 || int'(exp_q[i].dat[f_bit]) != f_mode))
            fp = p;
        if (fp >= 0) begin
          if (fl == 0) begin
            el = exp_q[i].elem; ad = int'(exp_q[i].adr); pt = fp;
          end
          fl = 1;
          if (cnt < 255) cnt++;
        end
      end
    end
  endtask

  function automatic logic [0:31] mkctl(bit bg, logic [3:0] mask);
    logic [0:31] c;
    c = '0;
    c[0] = 1'b1;
    c[2] = bg;
    for (int i = 0; i < 4; i++) c[4+i] = mask[i];
    return c;
  endfunction

  // One full run on dut; checks op stream, busy length and status against the model
  task automatic do_run(input string tag, input bit bg, input logic [3:0] mask);
    int busy_n, opbad, fl, cnt, el, pt, ad;
    bit ok;
    string first;
    build_ops(bg);
    busy_n = 0; opbad = 0; first = "";
    ctl = mkctl(bg, mask);
    @(negedge clk);
    ctl = '0;
    while (status[0] && busy_n < 2000) begin
      rd_enb_in = 2'($urandom); rd_adr_in = 12'($urandom);
      wr_enb_in = 1'($urandom); wr_adr_in = 6'($urandom);
      wr_dat_in = 72'({$urandom, $urandom, $urandom});
      #1;
      if (busy_n < exp_q.size()) begin
        if (exp_q[busy_n].rd)
          ok = (rd_enb_out == 2'b11) && !wr_enb_out && (rd_adr_out[5:0] == exp_q[busy_n].adr) &&
               (rd_adr_out[11:6] == exp_q[busy_n].adr);
        else
          ok = (rd_enb_out == 2'b00) && wr_enb_out && (wr_adr_out == exp_q[busy_n].adr) &&
               (wr_dat_out == exp_q[busy_n].dat);
      end else begin
        ok = (rd_enb_out == 2'b00) && !wr_enb_out;
      end
      if (!ok) begin
        if (opbad == 0) first = $sformatf(" first at cycle %0d", busy_n);
        opbad++;
      end
      busy_n++;
      @(negedge clk);
    end
    rd_enb_in = '0; rd_adr_in = '0; wr_enb_in = 1'b0; wr_adr_in = '0; wr_dat_in = '0;
    model_result(mask, fl, cnt, el, pt, ad);
    chk({tag, " busy_cycles"}, busy_n, 10 * N + 1);
    if (opbad != 0) $display("FAIL %s op_stream bad_ops=%0d required=0%s", tag, opbad, first);
    checks++;
    if (opbad != 0) errors++;
    chk({tag, " done"}, status[1], 1);
    chk({tag, " fail"}, status[2], fl);
    chk({tag, " count"}, status[8:15], cnt);
    if (fl != 0) begin
      chk({tag, " ff_elem"}, status[3:5], el);
      chk({tag, " ff_port"}, status[6:7], pt);
      chk({tag, " ff_adr"}, status[16:31], ad);
    end
  endtask

  typedef struct {
    logic [1:0]  rd_enb;
    logic [11:0] rd_adr;
    logic        wr_enb;
    logic [5:0]  wr_adr;
    logic [71:0] wr_dat;
  } pt_t;

  typedef struct {
    bit         bg;
    logic [3:0] mask;
    logic       fen;
    logic [1:0] fpm;
    bit         fall;
    int         fadr, fbit, fmode;
    int         e_fail, e_cnt, e_elem, e_port, e_adr;
  } rvec_t;

  pt_t   ptv [4];
  rvec_t rv  [8];

  initial begin
    int busy2_n, rises;
    bit prevb;
    ptv[0] = '{2'b00, 12'h000, 1'b0, 6'h00, 72'h0};
    ptv[1] = '{2'b01, 12'hABC, 1'b1, 6'h3F, 72'hFF_0123_4567_89AB_CDEF};
    ptv[2] = '{2'b10, 12'h555, 1'b0, 6'h2A, 72'h80_0000_0000_0000_0001};
    ptv[3] = '{2'b11, 12'hFFF, 1'b1, 6'h15, 72'h5A_A5A5_5A5A_A5A5_5A5A};

    rv[0] = '{0, 4'hF,    0, 2'b00, 0, 0,    0,  0, 0, 0,   0, 0, 0};
    rv[1] = '{0, 4'b0011, 1, 2'b10, 0, 'h2A, 5,  1, 1, 3,   1, 1, 'h2A};
    rv[2] = '{0, 4'b0001, 1, 2'b10, 0, 'h2A, 5,  1, 0, 0,   0, 0, 0};
    rv[3] = '{1, 4'hF,    1, 2'b01, 0, 5,    0,  0, 1, 3,   1, 0, 5};
    rv[4] = '{0, 4'hF,    1, 2'b01, 0, 'h3F, 71, 0, 1, 2,   2, 0, 'h3F};
    rv[5] = '{0, 4'b0011, 1, 2'b11, 1, 0,    3,  2, 1, 255, 1, 0, 0};
    rv[6] = '{0, 4'b0010, 1, 2'b11, 1, 0,    3,  2, 1, 255, 1, 1, 0};
    rv[7] = '{0, 4'b0000, 1, 2'b11, 1, 0,    3,  2, 0, 0,   0, 0, 0};

    reset = 1'b1; ctl = '0; ctl2 = '0;
    rd_enb_in = '0; rd_adr_in = '0; wr_enb_in = 1'b0; wr_adr_in = '0; wr_dat_in = '0;
    rd_enb_in2 = '0; rd_adr_in2 = '0; wr_enb_in2 = 1'b0; wr_adr_in2 = '0; wr_dat_in2 = '0;
    f_en = 1'b0; f_pm = '0; f_all = 0; f_adr = 0; f_bit = 0; f_mode = 0;
    repeat (3) @(negedge clk);
    chk("reset_status", status, 0);
    chk("reset_status2", status2, 0);
    reset = 1'b0;
    @(negedge clk);
    rd_adr_in = {6'h15, 6'h00};
    #1;
    chk("pass_rd_adr_p1", rd_adr_out[11:6], 6'h15);
    chk("idle_status", status, 0);

    for (int i = 0; i < 4; i++) begin
      rd_enb_in = ptv[i].rd_enb; rd_adr_in = ptv[i].rd_adr;
      wr_enb_in = ptv[i].wr_enb; wr_adr_in = ptv[i].wr_adr; wr_dat_in = ptv[i].wr_dat;
      #1;
      chk($sformatf("pass%0d rd_enb", i), rd_enb_out, ptv[i].rd_enb);
      chk($sformatf("pass%0d rd_adr", i), rd_adr_out, ptv[i].rd_adr);
      chk($sformatf("pass%0d wr_enb", i), wr_enb_out, ptv[i].wr_enb);
      chk($sformatf("pass%0d wr_adr", i), wr_adr_out, ptv[i].wr_adr);
      chk($sformatf("pass%0d wr_dat", i), wr_dat_out, ptv[i].wr_dat);
      @(negedge clk);
    end
    rd_enb_in = '0; rd_adr_in = '0; wr_enb_in = 1'b0; wr_adr_in = '0; wr_dat_in = '0;

    for (int i = 0; i < 8; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      f_en = rv[i].fen; f_pm = rv[i].fpm; f_all = rv[i].fall;
      f_adr = rv[i].fadr; f_bit = rv[i].fbit; f_mode = rv[i].fmode;
      do_run(tag, rv[i].bg, rv[i].mask);
      chk({tag, " tbl_fail"}, status[2], rv[i].e_fail);
      chk({tag, " tbl_count"}, status[8:15], rv[i].e_cnt);
      chk({tag, " tbl_elem"}, status[3:5], rv[i].e_elem);
      chk({tag, " tbl_port"}, status[6:7], rv[i].e_port);
      chk({tag, " tbl_adr"}, status[16:31], rv[i].e_adr);
      repeat (2) @(negedge clk);
    end

    for (int r = 0; r < 5; r++) begin
      f_en = 1'b1; f_pm = 2'($urandom_range(1, 3)); f_all = ($urandom_range(0, 3) == 0);
      f_adr = $urandom_range(0, 63); f_bit = $urandom_range(0, 71); f_mode = $urandom_range(0, 2);
      do_run($sformatf("rand%0d", r), 1'($urandom), 4'($urandom));
      @(negedge clk);
    end

    // Abort during RUN cycle 100 with every read failing on port 0
    f_en = 1'b1; f_pm = 2'b01; f_all = 1; f_bit = 0; f_mode = 2;
    ctl = mkctl(0, 4'hF);
    @(negedge clk);
    ctl = '0;
    repeat (100) @(negedge clk);
    chk("abort busy_before", status[0], 1);
    ctl[1] = 1'b1;
    @(negedge clk);
    ctl = '0;
    chk("abort busy", status[0], 0);
    chk("abort done", status[1], 0);
    chk("abort fail", status[2], 1);
    chk("abort count", status[8:15], 18);
    chk("abort ff_elem", status[3:5], 1);
    chk("abort ff_port", status[6:7], 0);
    chk("abort ff_adr", status[16:31], 0);
    rd_enb_in = 2'b10; wr_adr_in = 6'h33; wr_enb_in = 1'b1;
    #1;
    chk("abort pass_rd_enb", rd_enb_out, 2'b10);
    chk("abort pass_wr_adr", wr_adr_out, 6'h33);
    chk("abort pass_wr_enb", wr_enb_out, 1);
    rd_enb_in = '0; wr_adr_in = '0; wr_enb_in = 1'b0;
    @(negedge clk);
    f_en = 1'b0;
    do_run("after_abort", 0, 4'hF);

    // Reset in the middle of a run
    ctl = mkctl(0, 4'hF);
    @(negedge clk);
    ctl = '0;
    repeat (300) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd_adr_in = 12'h9C3;
    #1;
    chk("midreset status", status, 0);
    chk("midreset pass_rd_adr", rd_adr_out, 12'h9C3);
    reset = 1'b0;
    rd_adr_in = '0;
    repeat (2) @(negedge clk);
    chk("midreset stays_idle", status, 0);

    // Start held high on the small instance: exactly one checkerboard run
    ctl2 = mkctl(1, 4'hF);
    busy2_n = 0; rises = 0; prevb = 0;
    repeat (400) begin
      @(negedge clk);
      if (status2[0]) busy2_n++;
      if (status2[0] && !prevb) rises++;
      prevb = status2[0];
    end
    chk("hold busy_cycles", busy2_n, 162);
    chk("hold runs", rises, 1);
    chk("hold done", status2[1], 1);
    chk("hold fail", status2[2], 0);
    chk("hold count", status2[8:15], 0);
    ctl2 = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #(5_000_000);
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
